// File: rtl/credit_return_scheduler_pkg.sv
// Shared types for the credit return scheduler: FSM states, VC id and the
// round-robin pick helper used by both the normal and init-advertise paths.
package chiplet_types_pkg;

  localparam int NUM_VC = 2;

  typedef logic vc_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    INIT  = 2'd3
  } cred_sched_state_t;

  // Preferred VC if it is eligible, otherwise the other one.
  function automatic vc_id_t rr_pick(input logic [NUM_VC-1:0] elig, input vc_id_t pref);
    return elig[pref] ? pref : ~pref;
  endfunction

endpackage

// File: rtl/credit_return_scheduler_credit_accumulator.sv
// Per-VC released-slot accumulator: one increment and one BATCH decrement per
// cycle, saturating at BUF_DEPTH with a single-cycle overflow indication.
module credit_accumulator #(
  parameter int BUF_DEPTH = 16,
  parameter int BATCH     = 4,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] acc_o,
  output logic             ovf_o,
  output logic             ge_batch_o
);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   sum;

  // dec_i is only raised when acc_q >= BATCH, so the sum never goes negative.
  always_comb begin
    sum = {1'b0, acc_q} + {{CNT_W{1'b0}}, inc_i};
    if (dec_i) sum = sum - (CNT_W+1)'(BATCH);
    ovf_o = (sum > (CNT_W+1)'(BUF_DEPTH));
    acc_d = ovf_o ? CNT_W'(BUF_DEPTH) : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o      = acc_q;
  assign ge_batch_o = (acc_q >= CNT_W'(BATCH));

endmodule

// File: rtl/credit_return_scheduler.sv
// Turns per-VC slot releases into spaced, round-robin grant-credit comma writes.
// Optional CRED_INIT_ADVERT_EN: advertise the full buffer as grants after reset.
module credit_return_scheduler
  import chiplet_types_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int BATCH     = 4,
  parameter int SPACING   = 2,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       slot_free,
  input  logic             link_up,
  input  logic             grtcred_0_full,
  input  logic             grtcred_1_full,
  output logic             grtcred0_write,
  output logic             grtcred1_write,
  output logic [CNT_W-1:0] pending_cred_0,
  output logic [CNT_W-1:0] pending_cred_1,
  output logic             cred_ovf_err,
  output logic [1:0]       dbg_state_o
);

  localparam int SP_W = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam logic [SP_W-1:0] HOLD_LOAD = (SPACING > 0) ? SP_W'(SPACING - 1) : '0;

  cred_sched_state_t state_q, ret_state;
  vc_id_t            sel_q, rr_q, init_pick;
  logic [SP_W-1:0]   hold_cnt_q;
  logic              ovf_err_q;
  logic [NUM_VC-1:0] full, ge_batch, ovf, elig, cur_elig, init_elig, write, dec;
  logic              issue_ok, init_mode, init_any_d;
  logic [CNT_W-1:0]  acc [NUM_VC];

  assign full     = {grtcred_1_full, grtcred_0_full};
  assign elig     = {NUM_VC{link_up}} & ge_batch & ~full;
  assign cur_elig = init_mode ? init_elig : elig;
  // Eligibility is re-checked in ISSUE so a late full/link drop suppresses the write.
  assign issue_ok = (state_q == ISSUE) && cur_elig[sel_q];

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      write[v] = issue_ok && (sel_q == vc_id_t'(v));
      dec[v]   = write[v] && !init_mode;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_acc
    credit_accumulator #(
      .BUF_DEPTH(BUF_DEPTH),
      .BATCH    (BATCH),
      .CNT_W    (CNT_W)
    ) u_acc (
      .clk_i     (CLK),
      .rst_ni    (nRST),
      .inc_i     (slot_free[v]),
      .dec_i     (dec[v]),
      .acc_o     (acc[v]),
      .ovf_o     (ovf[v]),
      .ge_batch_o(ge_batch[v])
    );
  end

`ifdef CRED_INIT_ADVERT_EN
  localparam int INIT_N = BUF_DEPTH / BATCH;
  localparam int IC_W   = $clog2(INIT_N + 1);
  localparam cred_sched_state_t RESET_STATE = INIT;

  logic [NUM_VC-1:0][IC_W-1:0] init_cnt_q, init_cnt_d;
  vc_id_t                      init_rr_q;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++)
      init_elig[v] = link_up && !full[v] && (init_cnt_q[v] != '0);
  end

  // Init grants only consume the advertise budget, never the accumulators.
  always_comb begin
    init_cnt_d = init_cnt_q;
    for (int v = 0; v < NUM_VC; v++)
      if (write[v] && init_mode) init_cnt_d[v] = init_cnt_q[v] - IC_W'(1);
  end

  assign init_mode  = |init_cnt_q;
  assign init_any_d = |init_cnt_d;
  assign init_pick  = rr_pick(init_elig, init_rr_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      init_cnt_q <= {NUM_VC{IC_W'(INIT_N)}};
      init_rr_q  <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      if (issue_ok && init_mode) init_rr_q <= ~sel_q;
    end
  end
`else
  localparam cred_sched_state_t RESET_STATE = IDLE;

  assign init_elig  = '0;
  assign init_pick  = 1'b0;
  assign init_mode  = 1'b0;
  assign init_any_d = 1'b0;
`endif

  assign ret_state = init_any_d ? INIT : IDLE;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RESET_STATE;
      sel_q      <= 1'b0;
      rr_q       <= 1'b0;
      hold_cnt_q <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_q | (|ovf);
      case (state_q)
        IDLE: if (|elig) begin
          sel_q   <= rr_pick(elig, rr_q);
          state_q <= ISSUE;
        end
        INIT: if (|init_elig) begin
          sel_q   <= init_pick;
          state_q <= ISSUE;
        end
        ISSUE: begin
          if (issue_ok && !init_mode) rr_q <= ~sel_q;
          if (issue_ok && SPACING > 0) begin
            hold_cnt_q <= HOLD_LOAD;
            state_q    <= HOLD;
          end else begin
            state_q <= ret_state;
          end
        end
        HOLD: begin
          if (hold_cnt_q == '0) state_q <= ret_state;
          else                  hold_cnt_q <= hold_cnt_q - SP_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grtcred0_write = write[0];
  assign grtcred1_write = write[1];
  assign pending_cred_0 = acc[0];
  assign pending_cred_1 = acc[1];
  assign cred_ovf_err   = ovf_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_credit_return_scheduler.sv
// Bench for credit_return_scheduler (default build, init advertise disabled).
module tb_credit_return_scheduler;
  import chiplet_types_pkg::*;

  localparam int BUF_DEPTH = 16;
  localparam int BATCH     = 4;
  localparam int SPACING   = 2;
  localparam int CNT_W     = 5;

  // ---------------- clock / reset ----------------
  logic             CLK = 1'b0;
  logic             nRST = 1'b1;
  logic [1:0]       slot_free = 2'b00;
  logic             link_up = 1'b0;
  logic             full0 = 1'b0, full1 = 1'b0;
  logic             w0, w1, ovf;
  logic [CNT_W-1:0] p0, p1;
  logic [1:0]       dbg;

  always #5 CLK = ~CLK;

  credit_return_scheduler #(
    .BUF_DEPTH(BUF_DEPTH), .BATCH(BATCH), .SPACING(SPACING), .CNT_W(CNT_W)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .slot_free     (slot_free),
    .link_up       (link_up),
    .grtcred_0_full(full0),
    .grtcred_1_full(full1),
    .grtcred0_write(w0),
    .grtcred1_write(w1),
    .pending_cred_0(p0),
    .pending_cred_1(p1),
    .cred_ovf_err  (ovf),
    .dbg_state_o   (dbg)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: credit counts plus a cycle stamp before which no new
  // grant decision may be taken, and the VC chosen for the coming grant slot.
  int m_acc[2];
  int m_rr, m_pend, m_next_idle, m_cyc;
  bit m_ovf;

  logic [1:0]       last_w, last_state;
  logic [CNT_W-1:0] last_p0, last_p1;
  logic             last_ovf;
  logic [1:0]       exp_q[$];

  typedef struct {
    logic [1:0] sf;
    logic       lu;
    logic [1:0] fl;
    logic [1:0] ew;
    int         ep0;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc[0] = 0; m_acc[1] = 0;
    m_rr = 0; m_pend = -1; m_next_idle = 0; m_cyc = 0; m_ovf = 0;
  endfunction

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the next one.
  task automatic run_cycle(input logic [1:0] sf, input logic lu, input logic [1:0] fl);
    logic [1:0] el, ew;
    slot_free = sf; link_up = lu; {full1, full0} = fl;
    @(negedge CLK);
    last_w = {w1, w0}; last_p0 = p0; last_p1 = p1; last_ovf = ovf; last_state = dbg;
    for (int v = 0; v < 2; v++) el[v] = lu && (m_acc[v] >= BATCH) && !fl[v];
    ew = 2'b00;
    if (m_pend >= 0 && el[m_pend]) ew[m_pend] = 1'b1;
    check("write", last_w, ew);
    check("pend0", last_p0, m_acc[0]);
    check("pend1", last_p1, m_acc[1]);
    check("ovf", last_ovf, m_ovf);
    if (m_pend >= 0) begin
      if (el[m_pend]) begin
        m_acc[m_pend] -= BATCH;
        m_rr = 1 - m_pend;
        m_next_idle = m_cyc + 1 + SPACING;
      end else begin
        m_next_idle = m_cyc + 1;
      end
      m_pend = -1;
    end else if (m_cyc >= m_next_idle && el != 2'b00) begin
      m_pend = el[m_rr] ? m_rr : 1 - m_rr;
    end
    for (int v = 0; v < 2; v++) begin
      m_acc[v] += sf[v];
      if (m_acc[v] > BUF_DEPTH) begin
        m_acc[v] = BUF_DEPTH;
        m_ovf = 1;
      end
    end
    m_cyc++;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; slot_free = 2'b00; link_up = 1'b0; {full1, full0} = 2'b00;
    #2;
    check("rst_write", {w1, w0}, 2'b00);
    check("rst_pend0", p0, 0);
    check("rst_pend1", p1, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", dbg, IDLE);
    model_reset();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int prev_cyc;
    logic [1:0] exp_w;

    vecs[0]  = '{2'b01, 1'b1, 2'b00, 2'b00, 0};
    vecs[1]  = '{2'b01, 1'b1, 2'b00, 2'b00, 1};
    vecs[2]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2};
    vecs[3]  = '{2'b01, 1'b1, 2'b00, 2'b00, 3};
    vecs[4]  = '{2'b00, 1'b1, 2'b00, 2'b00, 4};
    vecs[5]  = '{2'b00, 1'b1, 2'b00, 2'b01, 4};
    vecs[6]  = '{2'b00, 1'b1, 2'b00, 2'b00, 0};
    vecs[7]  = '{2'b00, 1'b1, 2'b00, 2'b00, 0};
    vecs[8]  = '{2'b01, 1'b1, 2'b01, 2'b00, 0};
    vecs[9]  = '{2'b01, 1'b1, 2'b01, 2'b00, 1};
    vecs[10] = '{2'b01, 1'b1, 2'b01, 2'b00, 2};
    vecs[11] = '{2'b01, 1'b1, 2'b01, 2'b00, 3};
    vecs[12] = '{2'b00, 1'b1, 2'b01, 2'b00, 4};
    vecs[13] = '{2'b00, 1'b1, 2'b01, 2'b00, 4};
    vecs[14] = '{2'b00, 1'b1, 2'b00, 2'b00, 4};
    vecs[15] = '{2'b00, 1'b1, 2'b00, 2'b01, 4};
    vecs[16] = '{2'b00, 1'b1, 2'b00, 2'b00, 0};

    #1;
    do_reset();

    // Batch of four frees, then a blocked VC0 released by dropping full.
    for (int i = 0; i < 17; i++) begin
      run_cycle(vecs[i].sf, vecs[i].lu, vecs[i].fl);
      check("tbl_write", last_w, vecs[i].ew);
      check("tbl_pend0", last_p0, vecs[i].ep0);
    end

    // Full raised exactly on the ISSUE cycle suppresses the write.
    for (int i = 0; i < 4; i++) run_cycle(2'b01, 1'b1, 2'b01);
    run_cycle(2'b00, 1'b1, 2'b01);
    check("blocked", last_w, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b01);
    check("issue_state", last_state, ISSUE);
    check("full_in_issue", last_w, 2'b00);
    check("acc_kept", last_p0, 4);
    run_cycle(2'b00, 1'b1, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    check("write_after_drop", last_w, 2'b01);

    // Free on the ISSUE cycle: 4 + 1 - 4.
    for (int i = 0; i < 4; i++) run_cycle(2'b01, 1'b0, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    run_cycle(2'b01, 1'b1, 2'b00);
    check("issue_with_free", last_w, 2'b01);
    run_cycle(2'b00, 1'b1, 2'b00);
    check("acc_after_free_issue", last_p0, 1);

    // Both VCs at 8: alternating grants, SPACING+2 apart.
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(2'b11, 1'b0, 2'b00);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    prev_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      run_cycle(2'b00, 1'b1, 2'b00);
      if (last_w != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("extra_write", last_w, 2'b00);
        end else begin
          exp_w = exp_q.pop_front();
          check("rr_order", last_w, exp_w);
        end
        if (prev_cyc >= 0) check("grant_gap", m_cyc - prev_cyc, SPACING + 2);
        prev_cyc = m_cyc;
      end
    end
    check("rr_left", exp_q.size(), 0);

    // Reset while in HOLD discards credits and rr state.
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(2'b11, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) run_cycle(2'b10, 1'b0, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    check("hold_first", last_w, 2'b01);
    run_cycle(2'b00, 1'b1, 2'b00);
    check("hold_state", last_state, HOLD);
    check("hold_acc1", last_p1, 7);
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(2'b11, 1'b0, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    run_cycle(2'b00, 1'b1, 2'b00);
    check("post_rst_vc0_pref", last_w, 2'b01);

    // Overflow: 17 frees with the link down.
    do_reset();
    for (int i = 0; i < 17; i++) run_cycle(2'b01, 1'b0, 2'b00);
    run_cycle(2'b00, 1'b0, 2'b00);
    check("ovf_sat", last_p0, BUF_DEPTH);
    check("ovf_flag", last_ovf, 1);
    for (int i = 0; i < 3; i++) run_cycle(2'b00, 1'b0, 2'b00);
    check("ovf_sticky", last_ovf, 1);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        run_cycle(2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) != 0),
                  {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
